// File: rtl/fx_div_pipe_ctrl.sv
// Iterative radix-2^R restoring divider, q = a / b with signed a, unsigned b, saturating.
// Latency: o_valid rises ITERS+2 edges after the accept edge, independent of operand values.
// Backpressure: result held in DONE until i_ready; o_ready low while busy or while a result is held unconsumed.
module fx_div_pipe_ctrl #(
    parameter int W      = 16,
    parameter int A_FRAC = 14,
    parameter int B_FRAC = 14,
    parameter int Q_FRAC = 14,
    parameter int R      = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_q,
    output logic         o_ovf,
    output logic         o_dbz
);

    localparam int SH    = Q_FRAC + B_FRAC - A_FRAC;
    localparam int N     = W + SH;
    localparam int ITERS = (N + R - 1) / R;
    localparam int NP    = ITERS * R;
    localparam int CW    = $clog2(ITERS + 1);

    localparam logic [CW-1:0] LAST   = CW'(ITERS);
    localparam logic [W-1:0]  MAXQ   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MINQ   = {1'b1, {(W-1){1'b0}}};
    localparam logic [NP-1:0] POS_LIM = NP'(MAXQ);
    localparam logic [NP-1:0] NEG_LIM = NP'(MINQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;

    logic [CW-1:0] cnt_q;
    logic          neg_q;
    logic [W-1:0]  mag_q;
    logic [W-1:0]  b_q;
    logic [NP-1:0] num_q;
    logic [W-1:0]  rem_q;
    logic [NP-1:0] quo_q;

    logic [W:0]    rem_t;
    logic [NP-1:0] num_t;
    logic [NP-1:0] quo_t;

    logic [W-1:0]  res_q;
    logic          res_ovf;
    logic          res_dbz;

    assign accept = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CALC spends its first cycle loading the numerator, then ITERS iteration cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_CALC;
            S_CALC: if (cnt_q == LAST) state_d = S_POST;
            S_POST: state_d = S_DONE;
            S_DONE: begin
                if (accept) begin
                    state_d = S_CALC;
                end else if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_flush) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b0;
        case (state_q)
            S_IDLE:  o_ready = 1'b1;
            S_DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b0;
            end
        endcase
    end

    // R restoring steps per cycle; the remainder stays below b, so W+1 bits cover the shifted value.
    always_comb begin
        rem_t = {1'b0, rem_q};
        num_t = num_q;
        quo_t = quo_q;
        for (int j = 0; j < R; j++) begin
            rem_t = {rem_t[W-1:0], num_t[NP-1]};
            num_t = num_t << 1;
            if (rem_t >= {1'b0, b_q}) begin
                rem_t = rem_t - {1'b0, b_q};
                quo_t = {quo_t[NP-2:0], 1'b1};
            end else begin
                quo_t = {quo_t[NP-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        res_q   = '0;
        res_ovf = 1'b0;
        res_dbz = 1'b0;
        if (b_q == '0) begin
            res_dbz = 1'b1;
            res_q   = neg_q ? MINQ : MAXQ;
        end else if (!neg_q) begin
            if (quo_q > POS_LIM) begin
                res_q   = MAXQ;
                res_ovf = 1'b1;
            end else begin
                res_q = quo_q[W-1:0];
            end
        end else begin
            if (quo_q > NEG_LIM) begin
                res_q   = MINQ;
                res_ovf = 1'b1;
            end else begin
                res_q = -quo_q[W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            neg_q <= 1'b0;
            mag_q <= '0;
            b_q   <= '0;
            num_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            o_q   <= '0;
            o_ovf <= 1'b0;
            o_dbz <= 1'b0;
        end else if (i_flush) begin
            o_q   <= '0;
            o_ovf <= 1'b0;
            o_dbz <= 1'b0;
        end else begin
            if (state_q == S_DONE && i_ready) begin
                o_q   <= '0;
                o_ovf <= 1'b0;
                o_dbz <= 1'b0;
            end
            if (accept) begin
                neg_q <= i_a[W-1];
                mag_q <= i_a[W-1] ? -i_a : i_a;
                b_q   <= i_b;
                cnt_q <= '0;
            end
            if (state_q == S_CALC) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == '0) begin
                    // Leading zeros pad the numerator so its value is unchanged when N < ITERS*R.
                    num_q <= NP'(mag_q) << SH;
                    rem_q <= '0;
                    quo_q <= '0;
                end else begin
                    num_q <= num_t;
                    rem_q <= rem_t[W-1:0];
                    quo_q <= quo_t;
                end
            end
            if (state_q == S_POST) begin
                o_q   <= res_q;
                o_ovf <= res_ovf;
                o_dbz <= res_dbz;
            end
        end
    end

endmodule

// File: tb/tb_fx_div_pipe_ctrl.sv
// Bench for fx_div_pipe_ctrl at default parameters: directed vector table, handshake/flush/reset
// sequences, and random operands compared with an integer-arithmetic reference.
module tb_fx_div_pipe_ctrl;

    localparam int SH  = 14;
    localparam int LAT = 17;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_a = '0;
    logic [15:0] i_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_q;
    logic        o_ovf;
    logic        o_dbz;

    int checks = 0;
    int errors = 0;

    fx_div_pipe_ctrl dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_q     (o_q),
        .o_ovf   (o_ovf),
        .o_dbz   (o_dbz)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer quotient on magnitudes, then the saturation / divide-by-zero rules.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic ovf, output logic dbz);
        longint sa;
        longint abs_a;
        longint mag;
        sa    = longint'($signed(a));
        abs_a = (sa < 0) ? -sa : sa;
        ovf   = 1'b0;
        dbz   = 1'b0;
        q     = '0;
        if (b == 16'd0) begin
            dbz = 1'b1;
            q   = (sa < 0) ? 16'h8000 : 16'h7fff;
        end else begin
            mag = (abs_a * (longint'(1) << SH)) / longint'(b);
            if (sa >= 0) begin
                if (mag > 32767) begin
                    q = 16'h7fff;
                    ovf = 1'b1;
                end else begin
                    q = 16'(mag);
                end
            end else begin
                if (mag > 32768) begin
                    q = 16'h8000;
                    ovf = 1'b1;
                end else begin
                    q = 16'(-mag);
                end
            end
        end
    endfunction

    // Counts edges after an accept edge until o_valid is seen; -1 if it never rises.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic ovf, output logic dbz, output int lat);
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_a = a;
        i_b = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_a = 16'($urandom);
        i_b = 16'($urandom);
        wait_result(lat);
        q   = o_q;
        ovf = o_ovf;
        dbz = o_dbz;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        check("released", 32'(o_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] q;
        logic [15:0] eq;
        logic        ovf;
        logic        dbz;
        logic        eovf;
        logic        edbz;
        logic [15:0] held_q;
        logic        held_ovf;
        int          lat;
        int          r;

        vecs[0]  = '{16'd16384, 16'd16384, 16'd16384, 1'b0, 1'b0};
        vecs[1]  = '{16'hE000,  16'h8000,  16'hF000,  1'b0, 1'b0};
        vecs[2]  = '{16'd1,     16'd3,     16'd5461,  1'b0, 1'b0};
        vecs[3]  = '{16'hFFFF,  16'd3,     16'hEAAB,  1'b0, 1'b0};
        vecs[4]  = '{16'd16384, 16'd1,     16'h7FFF,  1'b1, 1'b0};
        vecs[5]  = '{16'h8000,  16'd16384, 16'h8000,  1'b0, 1'b0};
        vecs[6]  = '{16'h8000,  16'd8192,  16'h8000,  1'b1, 1'b0};
        vecs[7]  = '{16'hFFFB,  16'd0,     16'h8000,  1'b0, 1'b1};
        vecs[8]  = '{16'd0,     16'd0,     16'h7FFF,  1'b0, 1'b1};
        vecs[9]  = '{16'd0,     16'd5,     16'd0,     1'b0, 1'b0};
        vecs[10] = '{16'h7FFF,  16'hFFFF,  16'd8191,  1'b0, 1'b0};

        #12;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_q",     32'(o_q),     32'd0);
        check("reset_ovf",   32'(o_ovf),   32'd0);
        check("reset_dbz",   32'(o_dbz),   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, ovf, dbz, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_q", i),       32'(q),   32'(vecs[i].q));
            check($sformatf("vec%0d_ovf", i),     32'(ovf), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_dbz", i),     32'(dbz), 32'(vecs[i].dbz));
            consume();
        end

        // Hold the result under backpressure, then consume and accept on the same edge.
        run_op(16'd1, 16'd3, q, ovf, dbz, lat);
        check("bp_first_q", 32'(q), 32'd5461);
        held_q = o_q;
        held_ovf = o_ovf;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_q",     32'(o_q),     32'(held_q));
            check("bp_hold_ovf",   32'(o_ovf),   32'(held_ovf));
            check("bp_hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_a = 16'hE000;
        i_b = 16'h8000;
        #1;
        check("b2b_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        i_a = 16'h1234;
        i_b = 16'h0001;
        wait_result(lat);
        check("b2b_latency", 32'(lat), 32'(LAT));
        check("b2b_q",       32'(o_q), 32'hF000);
        consume();

        // Flush at CALC cycle 5 with an operand offered; the next op is accepted one cycle later.
        i_a = 16'd16384;
        i_b = 16'd16384;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_a = 16'd1;
        i_b = 16'd1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("flush_valid", 32'(o_valid), 32'd0);
        run_op(16'd1, 16'd3, q, ovf, dbz, lat);
        check("flush_next_latency", 32'(lat), 32'(LAT));
        check("flush_next_q",       32'(q),   32'd5461);
        consume();

        // Flush in IDLE must block the operand offered in the same cycle.
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_a = 16'd1;
        i_b = 16'd1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        wait_result(lat);
        check("flush_idle_no_result", 32'(lat), 32'hFFFFFFFF);

        // Reset while a saturated result is held clears everything without a clock edge.
        @(negedge i_clk);
        run_op(16'd16384, 16'd1, q, ovf, dbz, lat);
        check("pre_reset_ovf", 32'(ovf), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(o_valid), 32'd0);
        check("async_reset_q",     32'(o_q),     32'd0);
        check("async_reset_ovf",   32'(o_ovf),   32'd0);
        check("async_reset_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_result(lat);
        check("post_reset_no_result", 32'(lat), 32'hFFFFFFFF);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      rb = 16'd0;
            else if (r < 4)  rb = 16'($urandom_range(1, 64));
            else             rb = 16'($urandom);
            model(ra, rb, eq, eovf, edbz);
            run_op(ra, rb, q, ovf, dbz, lat);
            check($sformatf("rnd%0d_latency a=%0h b=%0h", n, ra, rb), 32'(lat), 32'(LAT));
            check($sformatf("rnd%0d_q a=%0h b=%0h", n, ra, rb),       32'(q),   32'(eq));
            check($sformatf("rnd%0d_ovf a=%0h b=%0h", n, ra, rb),     32'(ovf), 32'(eovf));
            check($sformatf("rnd%0d_dbz a=%0h b=%0h", n, ra, rb),     32'(dbz), 32'(edbz));
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
